// File: rtl/spi_txn_scheduler.sv
// Round-robin scheduler sharing one SPI master between NUM_REQS requesters.
// Each grant covers a whole transaction: accept, launch, wait for done/timeout, respond.
module spi_txn_scheduler #(
  parameter int NUM_REQS = 5,
  parameter int DATA_W   = 16,
  parameter int TMO_CYC  = 255
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQS-1:0]           req_valid,
  input  logic [NUM_REQS*DATA_W-1:0]    req_wdata,
  output logic [NUM_REQS-1:0]           req_ready,
  output logic [NUM_REQS-1:0]           rsp_valid,
  input  logic [NUM_REQS-1:0]           rsp_ready,
  output logic [DATA_W-1:0]             rsp_rdata,
  output logic                          rsp_err,
  output logic                          spi_start,
  output logic [DATA_W-1:0]             spi_wdata,
  input  logic                          spi_busy,
  input  logic                          spi_done,
  input  logic [DATA_W-1:0]             spi_rdata,
  output logic [$clog2(NUM_REQS)-1:0]   owner_id
);

  localparam int IDX_W = $clog2(NUM_REQS);
  localparam int CNT_W = $clog2(TMO_CYC + 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TMO_CYC - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_WAIT   = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  function automatic logic [NUM_REQS-1:0] onehot(input logic [IDX_W-1:0] idx);
    onehot = {{(NUM_REQS-1){1'b0}}, 1'b1} << idx;
  endfunction

  function automatic logic [NUM_REQS-1:0] rotl1(input logic [NUM_REQS-1:0] v);
    rotl1 = {v[NUM_REQS-2:0], v[NUM_REQS-1]};
  endfunction

  state_t               state_r, state_nxt;
  logic [NUM_REQS-1:0]  ptr_r, ptr_nxt;
  logic [IDX_W-1:0]     owner_r, owner_nxt;
  logic [DATA_W-1:0]    spi_wdata_r, wdata_nxt;
  logic                 spi_start_r, start_nxt;
  logic [CNT_W-1:0]     cnt_r, cnt_nxt;
  logic [NUM_REQS-1:0]  rsp_valid_r, rsp_valid_nxt;
  logic [DATA_W-1:0]    rsp_rdata_r, rsp_rdata_nxt;
  logic                 rsp_err_r, rsp_err_nxt;

  logic                 found_s;
  logic [IDX_W-1:0]     win_s;
  logic [DATA_W-1:0]    win_data_s;
  logic [NUM_REQS-1:0]  grant_s;

  // Round-robin pick: walk two laps of the request vector, only counting hits after ptr
  always_comb begin
    logic seen_v;
    logic hit_v;
    int   j;
    seen_v     = 1'b0;
    hit_v      = 1'b0;
    j          = 0;
    found_s    = 1'b0;
    win_s      = '0;
    win_data_s = '0;
    for (int i = 0; i < 2 * NUM_REQS; i++) begin
      j          = i % NUM_REQS;
      seen_v     = seen_v | ptr_r[j];
      hit_v      = seen_v & ~found_s & req_valid[j];
      win_s      = hit_v ? IDX_W'(j) : win_s;
      win_data_s = hit_v ? req_wdata[j*DATA_W +: DATA_W] : win_data_s;
      found_s    = found_s | hit_v;
    end
  end

  // Next-state and next-register values for the transaction FSM
  always_comb begin
    state_nxt     = state_r;
    ptr_nxt       = ptr_r;
    owner_nxt     = owner_r;
    wdata_nxt     = spi_wdata_r;
    start_nxt     = 1'b0;
    cnt_nxt       = cnt_r;
    rsp_valid_nxt = rsp_valid_r;
    rsp_rdata_nxt = rsp_rdata_r;
    rsp_err_nxt   = rsp_err_r;
    grant_s       = '0;
    case (state_r)
      ST_IDLE: begin
        if (found_s) begin
          grant_s   = onehot(win_s);
          owner_nxt = win_s;
          wdata_nxt = win_data_s;
          state_nxt = ST_LAUNCH;
        end else begin
          grant_s   = '0;
        end
      end
      ST_LAUNCH: begin
        cnt_nxt = '0;
        if (!spi_busy) begin
          start_nxt = 1'b1;
          state_nxt = ST_WAIT;
        end else begin
          state_nxt = ST_LAUNCH;
        end
      end
      ST_WAIT: begin
        cnt_nxt = cnt_r + CNT_W'(1);
        // A done landing on the last allowed cycle still counts as success
        if (spi_done) begin
          rsp_rdata_nxt = spi_rdata;
          rsp_err_nxt   = 1'b0;
          rsp_valid_nxt = onehot(owner_r);
          state_nxt     = ST_RESP;
        end else if (cnt_r == TMO_LAST) begin
          rsp_rdata_nxt = '0;
          rsp_err_nxt   = 1'b1;
          rsp_valid_nxt = onehot(owner_r);
          state_nxt     = ST_RESP;
        end else begin
          state_nxt     = ST_WAIT;
        end
      end
      ST_RESP: begin
        if (rsp_ready[owner_r]) begin
          rsp_valid_nxt = '0;
          rsp_err_nxt   = 1'b0;
          ptr_nxt       = rotl1(onehot(owner_r));
          owner_nxt     = '0;
          state_nxt     = ST_IDLE;
        end else begin
          state_nxt     = ST_RESP;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= ST_IDLE;
      ptr_r       <= {{(NUM_REQS-1){1'b0}}, 1'b1};
      owner_r     <= '0;
      spi_wdata_r <= '0;
      spi_start_r <= 1'b0;
      cnt_r       <= '0;
      rsp_valid_r <= '0;
      rsp_rdata_r <= '0;
      rsp_err_r   <= 1'b0;
    end else begin
      state_r     <= state_nxt;
      ptr_r       <= ptr_nxt;
      owner_r     <= owner_nxt;
      spi_wdata_r <= wdata_nxt;
      spi_start_r <= start_nxt;
      cnt_r       <= cnt_nxt;
      rsp_valid_r <= rsp_valid_nxt;
      rsp_rdata_r <= rsp_rdata_nxt;
      rsp_err_r   <= rsp_err_nxt;
    end
  end

  // The accept strobe is combinational, so mask it while reset is asserted
  assign req_ready = reset ? grant_s : '0;
  assign rsp_valid = rsp_valid_r;
  assign rsp_rdata = rsp_rdata_r;
  assign rsp_err   = rsp_err_r;
  assign spi_start = spi_start_r;
  assign spi_wdata = spi_wdata_r;
  assign owner_id  = owner_r;

endmodule

// File: tb/tb_spi_txn_scheduler.sv
// Directed bench for spi_txn_scheduler (TMO_CYC=8): reset, single transaction,
// round-robin order, timeout, busy/backpressure and corner cases.
module tb_spi_txn_scheduler;

  localparam int NR  = 5;
  localparam int DW  = 16;
  localparam int TMO = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic [NR-1:0]     req_valid;
  logic [NR*DW-1:0]  req_wdata;
  logic [NR-1:0]     req_ready;
  logic [NR-1:0]     rsp_valid;
  logic [NR-1:0]     rsp_ready;
  logic [DW-1:0]     rsp_rdata;
  logic              rsp_err;
  logic              spi_start;
  logic [DW-1:0]     spi_wdata;
  logic              spi_busy;
  logic              spi_done;
  logic [DW-1:0]     spi_rdata;
  logic [2:0]        owner_id;

  int errors = 0;
  int checks = 0;

  spi_txn_scheduler #(.NUM_REQS(NR), .DATA_W(DW), .TMO_CYC(TMO)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_wdata(req_wdata), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .spi_start(spi_start), .spi_wdata(spi_wdata), .spi_busy(spi_busy),
    .spi_done(spi_done), .spi_rdata(spi_rdata), .owner_id(owner_id)
  );

  always #5 clk = ~clk;

  function automatic logic [NR-1:0] oh(input int idx);
    logic [NR-1:0] one;
    one = NR'(1);
    return one << idx;
  endfunction

  task automatic step();
    @(negedge clk);
  endtask

  // Drives an already-accepted transaction to completion with fixed timing
  task automatic finish_txn();
    step(); req_valid = '0;
    step();
    step(); spi_done = 1'b1; spi_rdata = 16'h5555;
    step(); spi_done = 1'b0; rsp_ready = '1;
    step(); rsp_ready = '0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      step();
      req_valid = NR'($urandom);
      req_wdata = (NR*DW)'({$urandom, $urandom, $urandom});
      rsp_ready = NR'($urandom);
      spi_busy  = 1'($urandom);
      spi_done  = 1'($urandom);
      spi_rdata = DW'($urandom);
      #1;
      checks++;
      if ({req_ready, rsp_valid, rsp_rdata, rsp_err, spi_start, spi_wdata, owner_id} !== '0) begin
        errors++;
        $display("FAIL reset_outputs: got rr=%b rv=%b rd=%h er=%b st=%b wd=%h own=%0d expected all 0",
                 req_ready, rsp_valid, rsp_rdata, rsp_err, spi_start, spi_wdata, owner_id);
      end
    end
    step();
    req_valid = '0; req_wdata = '0; rsp_ready = '0; spi_busy = 1'b0; spi_done = 1'b0; spi_rdata = '0;
    reset = 1'b1;
    step();
    req_valid = 5'b00001;
    #1;
    checks++;
    if (req_ready !== 5'b00001) begin
      errors++; $display("FAIL reset_first_grant: got %b expected 00001", req_ready);
    end
    finish_txn();
  endtask

  task automatic test_single();
    int bad;
    bad = 0;
    req_valid = 5'b00100;
    req_wdata = {16'h4444, 16'h3333, 16'hA5A5, 16'h1111, 16'h0F0F};
    #1;
    checks++;
    if (req_ready !== 5'b00100) begin
      errors++; $display("FAIL single_accept: got %b expected 00100", req_ready);
    end
    step(); req_valid = '0; req_wdata = '1; #1;
    checks++;
    if (spi_start !== 1'b0 || spi_wdata !== 16'hA5A5 || owner_id !== 3'd2) begin
      errors++; $display("FAIL single_launch: got st=%b wd=%h own=%0d expected 0 a5a5 2", spi_start, spi_wdata, owner_id);
    end
    step(); #1;
    checks++;
    if (spi_start !== 1'b1) begin
      errors++; $display("FAIL single_start_t2: got %b expected 1", spi_start);
    end
    for (int c = 1; c <= 4; c++) begin
      step(); #1;
      if (spi_start !== 1'b0) bad++;
    end
    step(); spi_done = 1'b1; spi_rdata = 16'h3C3C; #1;
    if (spi_start !== 1'b0) bad++;
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL single_start_pulse: got %0d extra start cycles expected 0", bad);
    end
    step(); spi_done = 1'b0; #1;
    checks++;
    if (rsp_valid !== 5'b00100 || rsp_rdata !== 16'h3C3C || rsp_err !== 1'b0 || spi_wdata !== 16'hA5A5) begin
      errors++; $display("FAIL single_response: got rv=%b rd=%h er=%b wd=%h expected 00100 3c3c 0 a5a5",
                         rsp_valid, rsp_rdata, rsp_err, spi_wdata);
    end
    rsp_ready = 5'b00100;
    step(); rsp_ready = '0; #1;
    checks++;
    if (rsp_valid !== 5'b00000 || owner_id !== 3'd0) begin
      errors++; $display("FAIL single_release: got rv=%b own=%0d expected 00000 0", rsp_valid, owner_id);
    end
  endtask

  task automatic test_round_robin();
    int order [6] = '{0, 1, 2, 3, 4, 0};
    step(); reset = 1'b0;
    step(); reset = 1'b1;
    step(); req_valid = '1; rsp_ready = '1;
    for (int k = 0; k < 6; k++) begin
      #1;
      checks++;
      if (req_ready !== oh(order[k])) begin
        errors++; $display("FAIL rr_grant_%0d: got %b expected %b", k, req_ready, oh(order[k]));
      end
      step();
      step(); #1;
      checks++;
      if (spi_start !== 1'b1) begin
        errors++; $display("FAIL rr_start_%0d: got %b expected 1", k, spi_start);
      end
      step();
      step(); spi_done = 1'b1; spi_rdata = DW'(32'h1000 + k);
      step(); spi_done = 1'b0; #1;
      checks++;
      if (rsp_valid !== oh(order[k]) || rsp_rdata !== DW'(32'h1000 + k)) begin
        errors++; $display("FAIL rr_rsp_%0d: got rv=%b rd=%h expected %b %h", k, rsp_valid, rsp_rdata,
                           oh(order[k]), DW'(32'h1000 + k));
      end
      step();
    end
    req_valid = '0; rsp_ready = '0;
  endtask

  task automatic test_timeout();
    int bad;
    bad = 0;
    req_valid = 5'b01010;
    #1;
    checks++;
    if (req_ready !== 5'b00010) begin
      errors++; $display("FAIL tmo_accept: got %b expected 00010", req_ready);
    end
    step(); req_valid = 5'b01000;
    step(); #1;
    checks++;
    if (spi_start !== 1'b1) begin
      errors++; $display("FAIL tmo_start: got %b expected 1", spi_start);
    end
    for (int c = 1; c <= 7; c++) begin
      step(); #1;
      if (rsp_valid !== 5'b00000 || req_ready !== 5'b00000) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL tmo_early: got %0d early response/grant cycles expected 0", bad);
    end
    step(); #1;
    checks++;
    if (rsp_valid !== 5'b00010 || rsp_err !== 1'b1 || rsp_rdata !== 16'h0000 || req_ready !== 5'b00000) begin
      errors++; $display("FAIL tmo_response: got rv=%b er=%b rd=%h rr=%b expected 00010 1 0000 00000",
                         rsp_valid, rsp_err, rsp_rdata, req_ready);
    end
    rsp_ready = 5'b00010;
    step(); rsp_ready = '0; #1;
    checks++;
    if (req_ready !== 5'b01000 || rsp_err !== 1'b0) begin
      errors++; $display("FAIL tmo_next_owner: got rr=%b er=%b expected 01000 0", req_ready, rsp_err);
    end
    finish_txn();
  endtask

  task automatic test_backpressure();
    int bad;
    bad = 0;
    req_valid = 5'b00001; spi_busy = 1'b1;
    #1;
    checks++;
    if (req_ready !== 5'b00001) begin
      errors++; $display("FAIL bp_wrap_grant: got %b expected 00001", req_ready);
    end
    for (int c = 1; c <= 10; c++) begin
      step(); req_valid = '0; #1;
      if (spi_start !== 1'b0 || req_ready !== 5'b00000) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL bp_busy_hold: got %0d start/grant cycles expected 0", bad);
    end
    step(); spi_busy = 1'b0; #1;
    checks++;
    if (spi_start !== 1'b0) begin
      errors++; $display("FAIL bp_release_gap: got %b expected 0", spi_start);
    end
    step(); #1;
    checks++;
    if (spi_start !== 1'b1) begin
      errors++; $display("FAIL bp_start: got %b expected 1", spi_start);
    end
    step(); spi_done = 1'b1; spi_rdata = 16'hBEEF;
    step(); spi_done = 1'b0; req_valid = 5'b11110; rsp_ready = 5'b11110; #1;
    checks++;
    if (rsp_valid !== 5'b00001 || rsp_rdata !== 16'hBEEF) begin
      errors++; $display("FAIL bp_response: got rv=%b rd=%h expected 00001 beef", rsp_valid, rsp_rdata);
    end
    bad = 0;
    for (int c = 1; c <= 6; c++) begin
      step(); #1;
      if (rsp_valid !== 5'b00001 || rsp_rdata !== 16'hBEEF || req_ready !== 5'b00000) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL bp_rsp_stall: got %0d unstable cycles expected 0", bad);
    end
    step(); rsp_ready = 5'b00001;
    step(); rsp_ready = '0; #1;
    checks++;
    if (rsp_valid !== 5'b00000 || req_ready !== 5'b00010) begin
      errors++; $display("FAIL bp_handoff: got rv=%b rr=%b expected 00000 00010", rsp_valid, req_ready);
    end
    finish_txn();
  endtask

  task automatic test_corner();
    spi_done = 1'b1; spi_rdata = 16'hDEAD;
    step(); spi_done = 1'b0; #1;
    checks++;
    if (rsp_valid !== 5'b00000 || rsp_rdata !== 16'h5555 || spi_start !== 1'b0 || owner_id !== 3'd0) begin
      errors++; $display("FAIL corner_idle_done: got rv=%b rd=%h st=%b own=%0d expected 00000 5555 0 0",
                         rsp_valid, rsp_rdata, spi_start, owner_id);
    end
    req_valid = 5'b00100; #1;
    checks++;
    if (req_ready !== 5'b00100) begin
      errors++; $display("FAIL corner_accept: got %b expected 00100", req_ready);
    end
    step(); req_valid = '0;
    step(); #1;
    checks++;
    if (spi_start !== 1'b1) begin
      errors++; $display("FAIL corner_start: got %b expected 1", spi_start);
    end
    for (int c = 1; c <= 7; c++) step();
    spi_done = 1'b1; spi_rdata = 16'h1234;
    step(); spi_done = 1'b0; #1;
    checks++;
    if (rsp_valid !== 5'b00100 || rsp_err !== 1'b0 || rsp_rdata !== 16'h1234) begin
      errors++; $display("FAIL corner_done_vs_tmo: got rv=%b er=%b rd=%h expected 00100 0 1234",
                         rsp_valid, rsp_err, rsp_rdata);
    end
    rsp_ready = 5'b00100;
    step(); rsp_ready = '0; req_valid = 5'b01000; #1;
    checks++;
    if (req_ready !== 5'b01000) begin
      errors++; $display("FAIL corner_accept2: got %b expected 01000", req_ready);
    end
    step(); req_valid = '0;
    step();
    step(); reset = 1'b0; #1;
    checks++;
    if ({req_ready, rsp_valid, rsp_rdata, rsp_err, spi_start, spi_wdata, owner_id} !== '0) begin
      errors++; $display("FAIL corner_mid_reset: got rv=%b rd=%h st=%b wd=%h own=%0d expected all 0",
                         rsp_valid, rsp_rdata, spi_start, spi_wdata, owner_id);
    end
    step(); reset = 1'b1; spi_done = 1'b1; spi_rdata = 16'hFFFF;
    step(); spi_done = 1'b0; #1;
    checks++;
    if (rsp_valid !== 5'b00000 || owner_id !== 3'd0) begin
      errors++; $display("FAIL corner_no_rsp: got rv=%b own=%0d expected 00000 0", rsp_valid, owner_id);
    end
    req_valid = '1; #1;
    checks++;
    if (req_ready !== 5'b00001) begin
      errors++; $display("FAIL corner_ptr_reset: got %b expected 00001", req_ready);
    end
    finish_txn();
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_timeout();
    test_backpressure();
    test_corner();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish before 100000");
    $fatal(1);
  end

endmodule
